pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries an opaque payload bundle, such as aluop, alusel, operands, write address and write enable, concatenated by the instantiating stage. It generalises the fixed ID/EX latch:
- Stalls use back-pressure instead of dropped data.
- Flushes inject a bubble in one cycle.
- The skid option registers `up_ready`, so stall logic does not chain combinationally across stages.

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// synchronous flush and an optional two-entry skid buffer.
//
// Parameters:
//   DATA_W    - payload width in bits
//   NOP_VALUE - payload driven on dn_data while the stage holds a bubble
//   SKID      - 1: main + skid entry, registered up_ready
//               0: single entry, combinational up_ready
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   flush      - synchronous kill of all held and in-flight entries
//   up_valid   - upstream payload valid
//   up_ready   - stage can accept this cycle
//   up_data    - upstream payload
//   dn_valid   - dn_data holds a real instruction
//   dn_ready   - downstream accepts this cycle
//   dn_data    - payload to next stage (NOP_VALUE when dn_valid=0)
//   occupancy  - entries held (0..2)
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              rdy_q, rdy_d;
    logic              up_xfer, dn_xfer;

    assign dn_valid = (state_q != EMPTY);
    assign dn_data  = dn_valid ? m_q : NOP_VALUE;

    // rdy_q is 0 through reset and the first edge after it, so nothing is
    // accepted until the cycle after that edge. With SKID it also tracks
    // !FULL one cycle ahead, keeping up_ready free of any dn_ready path.
    if (SKID) begin : g_skid
        assign up_ready = rdy_q;
    end else begin : g_noskid
        assign up_ready = rdy_q && (!dn_valid || dn_ready);
    end

    assign up_xfer = up_valid && up_ready;
    assign dn_xfer = dn_valid && dn_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            // An up-transfer in this cycle still handshakes; its data is dropped.
            state_d = EMPTY;
            m_d     = NOP_VALUE;
            s_d     = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        m_d     = up_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (up_xfer && dn_xfer) begin
                        m_d = up_data;
                    end else if (up_xfer) begin
                        if (SKID) begin
                            s_d     = up_data;
                            state_d = FULL;
                        end else begin
                            m_d = up_data;
                        end
                    end else if (dn_xfer) begin
                        m_d     = NOP_VALUE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dn_xfer) begin
                        m_d     = s_q;
                        s_d     = NOP_VALUE;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    m_d     = NOP_VALUE;
                    s_d     = NOP_VALUE;
                end
            endcase
        end
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            m_q     <= NOP_VALUE;
            s_q     <= NOP_VALUE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. One instance
// with the skid buffer, one without; both are compared every cycle against
// a queue-style model, plus directed literal expectations.
module tb_pipe_stage_reg;

    localparam int unsigned W    = 16;
    localparam logic [W-1:0] NOP1 = 16'hF00D;
    localparam logic [W-1:0] NOP0 = 16'h0BAD;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         flush1 = 1'b0, u1_valid = 1'b0, d1_ready = 1'b0;
    logic [W-1:0] u1_data = '0;
    logic         up1_ready, dn1_valid;
    logic [W-1:0] dn1_data;
    logic [1:0]   occ1;

    logic         flush0 = 1'b0, u0_valid = 1'b0, d0_ready = 1'b0;
    logic [W-1:0] u0_data = '0;
    logic         up0_ready, dn0_valid;
    logic [W-1:0] dn0_data;
    logic [1:0]   occ0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP1), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .up_valid(u1_valid), .up_ready(up1_ready), .up_data(u1_data),
        .dn_valid(dn1_valid), .dn_ready(d1_ready), .dn_data(dn1_data),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .up_valid(u0_valid), .up_ready(up0_ready), .up_data(u0_data),
        .dn_valid(dn0_valid), .dn_ready(d0_ready), .dn_data(dn0_data),
        .occupancy(occ0)
    );

    // Model: a FIFO of up to two words plus a "seen an edge since reset" flag.
    typedef struct packed {
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [1:0]   cnt;
        logic         started;
    } mdl_t;

    localparam mdl_t MDL_RST = '{e0: '0, e1: '0, cnt: 2'd0, started: 1'b0};

    mdl_t m1 = MDL_RST;
    mdl_t m0 = MDL_RST;

    function automatic logic mdl_ready(mdl_t s, bit skid, logic dr);
        if (!s.started) return 1'b0;
        if (skid) return s.cnt < 2'd2;
        return (s.cnt == 2'd0) || dr;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit skid, logic uv, logic [W-1:0] ud,
                                      logic dr, logic fl);
        mdl_t r;
        logic up;
        logic dn;
        r  = s;
        up = uv && mdl_ready(s, skid, dr);
        dn = (s.cnt != 2'd0) && dr;
        r.started = 1'b1;
        if (fl) begin
            r.cnt = 2'd0;
        end else begin
            if (dn) begin
                r.e0  = s.e1;
                r.cnt = r.cnt - 2'd1;
            end
            if (up) begin
                if (r.cnt == 2'd0) r.e0 = ud;
                else               r.e1 = ud;
                r.cnt = r.cnt + 2'd1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 <= MDL_RST;
            m0 <= MDL_RST;
        end else begin
            m1 <= mdl_step(m1, 1'b1, u1_valid, u1_data, d1_ready, flush1);
            m0 <= mdl_step(m0, 1'b0, u0_valid, u0_data, d0_ready, flush0);
        end
    end

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chko(input string nm, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle with inputs stable.
    always @(negedge clk) begin
        chkb("cmp1_dn_valid", dn1_valid, m1.cnt != 2'd0);
        chkd("cmp1_dn_data", dn1_data, (m1.cnt != 2'd0) ? m1.e0 : NOP1);
        chko("cmp1_occupancy", occ1, m1.cnt);
        chkb("cmp1_up_ready", up1_ready, mdl_ready(m1, 1'b1, d1_ready));
        chkb("cmp0_dn_valid", dn0_valid, m0.cnt != 2'd0);
        chkd("cmp0_dn_data", dn0_data, (m0.cnt != 2'd0) ? m0.e0 : NOP0);
        chko("cmp0_occupancy", occ0, m0.cnt);
        chkb("cmp0_up_ready", up0_ready, mdl_ready(m0, 1'b0, d0_ready));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] stream [3] = '{16'h0011, 16'h0022, 16'h0033};

    initial begin
        // Reset state
        #1;
        chkb("rst_up_ready1", up1_ready, 1'b0);
        chkb("rst_dn_valid1", dn1_valid, 1'b0);
        chkd("rst_dn_data1", dn1_data, NOP1);
        chko("rst_occ1", occ1, 2'd0);
        chkb("rst_up_ready0", up0_ready, 1'b0);
        chkd("rst_dn_data0", dn0_data, NOP0);

        // Release between edges; the first edge must accept nothing
        #11 rst = 1'b1;
        u1_valid = 1'b1; u1_data = 16'h0011; d1_ready = 1'b1;
        #1 chkb("pre_first_edge_up_ready", up1_ready, 1'b0);
        tick();
        chkb("first_edge_no_accept", dn1_valid, 1'b0);
        chkb("ready_after_first_edge1", up1_ready, 1'b1);
        chkb("ready_after_first_edge0", up0_ready, 1'b1);

        // Streaming back-to-back
        for (int i = 0; i < 3; i++) begin
            u1_data = stream[i];
            tick();
            chkd("stream_data", dn1_data, stream[i]);
            chko("stream_occ", occ1, 2'd1);
        end
        u1_valid = 1'b0;
        tick();
        chkb("stream_drained", dn1_valid, 1'b0);

        // Skid fill and drain
        u1_valid = 1'b1; u1_data = 16'h00A1;
        tick();
        chkd("skid_one_a1", dn1_data, 16'h00A1);
        d1_ready = 1'b0; u1_data = 16'h00B2;
        tick();
        chko("skid_full_occ", occ1, 2'd2);
        chkb("skid_full_up_ready", up1_ready, 1'b0);
        u1_data = 16'h00C3;
        repeat (2) begin
            tick();
            chkd("skid_hold_a1", dn1_data, 16'h00A1);
            chko("skid_hold_occ", occ1, 2'd2);
        end
        u1_valid = 1'b0; d1_ready = 1'b1;
        tick();
        chkd("skid_drain_b2", dn1_data, 16'h00B2);
        chkb("skid_ready_back", up1_ready, 1'b1);
        tick();
        chko("skid_empty", occ1, 2'd0);

        // Stall hold
        d1_ready = 1'b0; u1_valid = 1'b1; u1_data = 16'hDEAD;
        tick();
        u1_data = 16'hBEEF;
        tick();
        chkb("stall_up_ready_low", up1_ready, 1'b0);
        u1_data = 16'hCAFE;
        repeat (5) begin
            tick();
            chkb("stall_valid", dn1_valid, 1'b1);
            chkd("stall_data", dn1_data, 16'hDEAD);
            chko("stall_occ", occ1, 2'd2);
        end
        u1_valid = 1'b0; d1_ready = 1'b1;
        tick();
        chkd("stall_drain_beef", dn1_data, 16'hBEEF);
        tick();
        chkb("stall_drained", dn1_valid, 1'b0);

        // Flush while FULL with an offered word
        d1_ready = 1'b0; u1_valid = 1'b1; u1_data = 16'h0001;
        tick();
        u1_data = 16'h0002;
        tick();
        chko("flush_pre_full", occ1, 2'd2);
        flush1 = 1'b1; u1_data = 16'h0003;
        tick();
        chkb("flush_dn_valid", dn1_valid, 1'b0);
        chkd("flush_dn_data", dn1_data, NOP1);
        chko("flush_occ", occ1, 2'd0);
        chkb("flush_up_ready", up1_ready, 1'b1);
        flush1 = 1'b0; u1_valid = 1'b0;
        tick();
        chkb("flush_stays_empty", dn1_valid, 1'b0);

        // Asynchronous reset mid-stream with two entries held
        u1_valid = 1'b1; u1_data = 16'h0055;
        tick();
        u1_data = 16'h0066;
        tick();
        chko("midrst_pre_full", occ1, 2'd2);
        u1_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chkb("midrst_dn_valid", dn1_valid, 1'b0);
        chkd("midrst_dn_data", dn1_data, NOP1);
        chko("midrst_occ", occ1, 2'd0);
        chkb("midrst_up_ready", up1_ready, 1'b0);
        tick();
        chkb("midrst_held_up_ready", up1_ready, 1'b0);
        #2 rst = 1'b1;
        u1_valid = 1'b1; u1_data = 16'h0077; d1_ready = 1'b1;
        tick();
        chkb("midrst_first_edge_no_accept", dn1_valid, 1'b0);
        chkb("midrst_ready_back", up1_ready, 1'b1);
        tick();
        chkd("midrst_after_77", dn1_data, 16'h0077);
        u1_valid = 1'b0;
        tick();

        // Single-entry mode
        d0_ready = 1'b0; u0_valid = 1'b1; u0_data = 16'h0010;
        tick();
        chkd("noskid_first", dn0_data, 16'h0010);
        chkb("noskid_ready_low", up0_ready, 1'b0);
        d0_ready = 1'b1;
        #1 chkb("noskid_ready_comb", up0_ready, 1'b1);
        u0_data = 16'h0020;
        tick();
        chkd("noskid_replace_20", dn0_data, 16'h0020);
        u0_data = 16'h0030;
        tick();
        chkd("noskid_replace_30", dn0_data, 16'h0030);
        chko("noskid_occ", occ0, 2'd1);
        d0_ready = 1'b0; u0_data = 16'h0040;
        tick();
        chkd("noskid_stalled_30", dn0_data, 16'h0030);
        tick();
        chkd("noskid_still_30", dn0_data, 16'h0030);
        u0_valid = 1'b0; d0_ready = 1'b1;
        tick();
        chkb("noskid_drained", dn0_valid, 1'b0);
        chkd("noskid_nop", dn0_data, NOP0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
